// File: rtl/uart_word_tx.sv
// uart_word_tx: buffers 32-bit words in a small FIFO and sends each as four 8N1 UART frames, MSB byte first.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [31:0]                   in_data,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   hold;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [1:0]    byte_idx, byte_idx_n;
    logic          push, pop, tick, tx_n;
    logic [7:0]    cur_byte;

    assign in_ready = fifo_count != FULL;
    assign busy     = state != IDLE || fifo_count != '0;
    assign push     = in_valid && in_ready;
    assign pop      = state == IDLE && fifo_count != '0;
    assign tick     = timer == LAST;
    assign cur_byte = hold[31:24];

    always_comb begin
        state_n    = state;
        timer_n    = tick ? '0 : timer + 1'b1;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        tx_n       = 1'b1;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (pop) begin
                    state_n    = START;
                    byte_idx_n = '0;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (tick) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                tx_n = cur_byte[bit_idx];
                if (tick) begin
                    bit_idx_n = bit_idx + 3'd1;
                    state_n   = bit_idx == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                if (tick) begin
                    state_n    = byte_idx != 2'd3 ? START : IDLE;
                    byte_idx_n = byte_idx + 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            tx         <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            hold       <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            tx         <= tx_n;
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            overflow   <= overflow | (in_valid & ~in_ready);
            // the next byte to send always sits in the top byte of hold
            if (pop)
                hold <= mem[rd_ptr];
            else if (state == STOP && tick)
                hold <= {hold[23:0], 8'h00};
        end
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: randomized word stream checked against a frame-level model of the UART output.
module tb_uart_word_tx;
    localparam int C = 4;
    localparam int D = 4;
    localparam int WORD = 40 * C;

    logic        clk = 0, rst = 1, in_valid = 0;
    logic [31:0] in_data = '0;
    logic        in_ready, tx, busy, overflow;
    logic [2:0]  fifo_count;

    uart_word_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx(tx), .busy(busy), .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [31:0] q[$];
    logic [31:0] cur;
    bit          loaded = 0, m_ovf = 0;
    int          t = 0;
    logic [6:0]  exp_vec;
    wire  [6:0]  obs = {tx, busy, in_ready, overflow, fifo_count};

    // bit i (0..39) of a word's line image: per byte start, 8 data LSB first, stop
    function automatic logic frame_bit(logic [31:0] w, int i);
        int b = i / 10;
        int p = i % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return w[8*(3-b) + p - 1];
    endfunction

    task automatic step(input logic v, input logic [31:0] d);
        bit   old_idle;
        int   old_n;
        logic etx;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (rst) begin
            q.delete();
            loaded = 0;
            m_ovf  = 0;
            t      = 0;
        end else begin
            old_idle = !loaded || t >= WORD;
            old_n    = q.size();
            if (loaded && t < WORD) t++;
            if (v && old_n == D) m_ovf = 1;
            if (old_idle && old_n > 0) begin
                cur    = q.pop_front();
                loaded = 1;
                t      = 0;
            end
            if (v && old_n != D) q.push_back(d);
        end
        etx = (loaded && t >= 1) ? frame_bit(cur, (t - 1) / C) : 1'b1;
        exp_vec = {etx, (loaded && t < WORD) || q.size() > 0, q.size() != D, m_ovf, 3'(q.size())};
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        step(0, 0);
        step(0, 0);
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            step(0, 0);
            total++;
            if (obs !== 7'b1010000) begin
                bad++;
                $display("FAIL reset_idle k=%0d got=%b exp=%b", k, obs, 7'b1010000);
            end
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL reset_model k=%0d got=%b exp=%b", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] a1 = 8'hA1;
        step(1, 32'hA1B2C3D4);
        for (int k = 1; k <= 170; k++) begin
            step(0, 0);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL single_vec k=%0d got=%b exp=%b", k, obs, exp_vec);
            end
            if (k == 1 || k == 2) begin
                total++;
                if (tx !== (k == 1)) begin
                    bad++;
                    $display("FAIL single_start k=%0d got=%b exp=%b", k, tx, k == 1);
                end
            end
            if (k >= 7 && k <= 35 && (k - 7) % 4 == 0) begin
                total++;
                if (tx !== a1[(k-7)/4]) begin
                    bad++;
                    $display("FAIL single_a1_bit%0d got=%b exp=%b", (k-7)/4, tx, a1[(k-7)/4]);
                end
            end
            if (k == 160 || k == 161) begin
                total++;
                if (busy !== (k == 160)) begin
                    bad++;
                    $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, k == 160);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ec[6] = '{1, 1, 2, 3, 4, 4};
        for (int i = 0; i < 6; i++) begin
            step(1, $urandom);
            total++;
            if (fifo_count !== 3'(ec[i]) || overflow !== (i == 5)) begin
                bad++;
                $display("FAIL b2b_fill i=%0d got=%0d/%b exp=%0d/%b", i, fifo_count, overflow, ec[i], i == 5);
            end
        end
        for (int k = 0; k < 5 * (WORD + 1) + 20; k++) begin
            step(0, 0);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL b2b_vec k=%0d got=%b exp=%b", k, obs, exp_vec);
            end
        end
        total++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end got=%b/%b exp=1/0", overflow, busy);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1, $urandom);
        for (int k = 0; k < 200 && t < 90; k++) begin
            step(0, 0);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL rmid_vec k=%0d got=%b exp=%b", k, obs, exp_vec);
            end
        end
        rst = 1;
        step(0, 0);
        rst = 0;
        total++;
        if (obs !== 7'b1010000) begin
            bad++;
            $display("FAIL rmid_reset got=%b exp=%b", obs, 7'b1010000);
        end
        for (int k = 0; k < 200; k++) begin
            step(0, 0);
            total++;
            if (tx !== 1'b1 || obs !== exp_vec) begin
                bad++;
                $display("FAIL rmid_quiet k=%0d got=%b exp=%b", k, obs, exp_vec);
            end
        end
    endtask

    task automatic test_push_pop();
        bit found = 0;
        for (int i = 0; i < 4; i++) step(1, $urandom);
        for (int k = 0; k < 400 && !found; k++) begin
            if (loaded && t == WORD && q.size() > 0) found = 1;
            else step(0, 0);
        end
        total++;
        if (!found || fifo_count !== 3'd3) begin
            bad++;
            $display("FAIL pp_setup got=%0d exp=3 found=%0d", fifo_count, found);
        end
        step(1, $urandom);
        total++;
        if (fifo_count !== 3'd3 || overflow !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pp_same_cycle got=%0d/%b/%b exp=3/0/1", fifo_count, overflow, busy);
        end
        for (int k = 0; k < 4 * (WORD + 1) + 20; k++) begin
            step(0, 0);
            total++;
            if (obs !== exp_vec) begin
                bad++;
                $display("FAIL pp_vec k=%0d got=%b exp=%b", k, obs, exp_vec);
            end
        end
        total++;
        if (busy !== 1'b0 || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL pp_drain got=%b/%0d exp=0/0", busy, fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_push_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
